instr_mem_responder: RTL and testbench

//  Instruction-memory responder: the memory side of the CPU fetch interface.

---
 rtl/instr_mem_responder_if.sv | 40 ++++
 rtl/instr_mem_responder.sv | 143 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module  : instr_mem_responder_if
// Brief   : Fetch request/response bus between the CPU fetch stage and memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_mem_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [31:0]       rsp_instr_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  req_addr_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_instr_o,
        output rsp_err_o
    );

    modport master (
        output req_valid_i,
        input  req_ready_o,
        output req_addr_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_instr_o,
        input  rsp_err_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : instr_mem_responder
// Brief   : Instruction memory with valid/ready fetch port, fixed wait states
//           and a side-band preload write port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    instr_mem_responder_if.slave       bus,
    input  wire logic                  ld_en_i,
    input  wire logic [DEPTH_LOG2-1:0] ld_addr_i,
    input  wire logic [31:0]           ld_data_i
);

    localparam int       c_depth = 1 << DEPTH_LOG2;
    localparam bit [3:0] c_wait  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_instr;
    logic              r_rsp_err;
    logic [31:0]       r_mem [0:c_depth-1];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_rsp_hs;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_accept = bus.req_valid_i && (r_state == S_IDLE);
    assign w_rsp_hs = r_rsp_valid && bus.rsp_ready_i;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // decode must look at the live request address instead of the latched one.
    assign w_addr     = (r_state == S_IDLE) ? bus.req_addr_i : r_addr;
    assign w_misalign = |w_addr[1:0];
    assign w_idx      = w_addr[DEPTH_LOG2+1:2];
    assign w_err      = w_misalign || w_oor;

    generate
        if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range_chk
            assign w_oor = |w_addr[ADDR_W-1:DEPTH_LOG2+2];
        end else begin : g_no_range_chk
            assign w_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_wait;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_nxt    = 4'd0;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr <= bus.req_addr_i;
            end
            // The array read sees the value before any same-edge preload write.
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_instr <= w_err ? 32'd0 : r_mem[w_idx];
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Program store is deliberately left out of reset so a loaded image survives.
    always_ff @(posedge clk_i) begin
        if (ld_en_i) begin
            r_mem[ld_addr_i] <= ld_data_i;
        end
    end

    assign bus.req_ready_o = (r_state == S_IDLE);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_instr_o = r_rsp_instr;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_instr_mem_responder
// Brief   : Directed bench for instr_mem_responder (2 and 0 wait states).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_responder;

    logic        clk_i;
    logic        rst_i;
    logic        ld_en_i;
    logic [7:0]  ld_addr_i;
    logic [31:0] ld_data_i;

    int n_checks;
    int n_err;
    int cyc;

    instr_mem_responder_if #(.ADDR_W(32)) bus2 ();
    instr_mem_responder_if #(.ADDR_W(32)) bus0 ();

    instr_mem_responder #(.ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut2 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus2.slave),
        .ld_en_i   (ld_en_i),
        .ld_addr_i (ld_addr_i),
        .ld_data_i (ld_data_i)
    );

    instr_mem_responder #(.ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus0.slave),
        .ld_en_i   (ld_en_i),
        .ld_addr_i (ld_addr_i),
        .ld_data_i (ld_data_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        ld_en_i   = 1'b1;
        ld_addr_i = a;
        ld_data_i = d;
        tick();
        ld_en_i   = 1'b0;
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic issue2(input logic [31:0] a);
        bus2.req_valid_i = 1'b1;
        bus2.req_addr_i  = a;
        tick();
        bus2.req_valid_i = 1'b0;
        bus2.req_addr_i  = 32'hFFFF_FFF0;
    endtask

    task automatic wait_rsp2(output int c);
        c = 0;
        while (bus2.rsp_valid_o !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        n_checks++;
        assert (bus2.rsp_valid_o === 1'b1) else begin
            n_err++;
            $error("FAIL rsp_timeout: observed=%b expected=1", bus2.rsp_valid_o);
        end
    endtask

    task automatic hs2();
        bus2.rsp_ready_i = 1'b1;
        tick();
        bus2.rsp_ready_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_i    = 1'b1;
        ld_en_i  = 1'b0;
        ld_addr_i = '0;
        ld_data_i = '0;
        bus2.req_valid_i = 1'b0;
        bus2.req_addr_i  = '0;
        bus2.rsp_ready_i = 1'b0;
        bus0.req_valid_i = 1'b0;
        bus0.req_addr_i  = '0;
        bus0.rsp_ready_i = 1'b0;
        #1 rst_i = 1'b0;
        tick();
        tick();

        chk("rst_ready",  {31'd0, bus2.req_ready_o}, 32'd1);
        chk("rst_valid",  {31'd0, bus2.rsp_valid_o}, 32'd0);
        chk("rst_instr",  bus2.rsp_instr_o, 32'd0);
        chk("rst_err",    {31'd0, bus2.rsp_err_o}, 32'd0);
        chk("rst0_ready", {31'd0, bus0.req_ready_o}, 32'd1);
        rst_i = 1'b1;
        tick();

        load(8'd0,   32'h2001_0005);
        load(8'd1,   32'h2002_0003);
        load(8'd2,   32'h1111_2222);
        load(8'd255, 32'hCAFE_F00D);

        // Fetch 0x0, three-cycle latency
        issue2(32'h0);
        chk("t1_busy", {31'd0, bus2.req_ready_o}, 32'd0);
        wait_rsp2(cyc);
        chk("t1_latency", 32'(cyc + 1), 32'd3);
        chk("t1_instr", bus2.rsp_instr_o, 32'h2001_0005);
        chk("t1_err", {31'd0, bus2.rsp_err_o}, 32'd0);
        hs2();
        chk("t1_idle", {31'd0, bus2.req_ready_o}, 32'd1);

        // Fetch 0x4 with a five-cycle stall; stray requests must be ignored
        issue2(32'h4);
        wait_rsp2(cyc);
        bus2.req_valid_i = 1'b1;
        bus2.req_addr_i  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_instr", bus2.rsp_instr_o, 32'h2002_0003);
            chk("t2_hold_busy", {31'd0, bus2.req_ready_o}, 32'd0);
            tick();
        end
        bus2.req_valid_i = 1'b0;
        chk("t2_valid_held", {31'd0, bus2.rsp_valid_o}, 32'd1);
        hs2();
        chk("t2_valid_drop", {31'd0, bus2.rsp_valid_o}, 32'd0);
        chk("t2_ready_back", {31'd0, bus2.req_ready_o}, 32'd1);

        // Misaligned, first out-of-range and last valid address
        issue2(32'h6);
        wait_rsp2(cyc);
        chk("t3_mis_err", {31'd0, bus2.rsp_err_o}, 32'd1);
        chk("t3_mis_instr", bus2.rsp_instr_o, 32'd0);
        hs2();
        issue2(32'h400);
        wait_rsp2(cyc);
        chk("t3_oor_err", {31'd0, bus2.rsp_err_o}, 32'd1);
        chk("t3_oor_instr", bus2.rsp_instr_o, 32'd0);
        hs2();
        issue2(32'h3FC);
        wait_rsp2(cyc);
        chk("t3_max_err", {31'd0, bus2.rsp_err_o}, 32'd0);
        chk("t3_max_instr", bus2.rsp_instr_o, 32'hCAFE_F00D);
        hs2();

        // Preload during WAIT is visible
        issue2(32'h8);
        load(8'd2, 32'hDEAD_BEEF);
        wait_rsp2(cyc);
        chk("t4_wait_load", bus2.rsp_instr_o, 32'hDEAD_BEEF);
        hs2();

        // Preload on the RESP-entry edge is not visible
        load(8'd2, 32'h1111_2222);
        issue2(32'h8);
        tick();
        load(8'd2, 32'hDEAD_BEEF);
        chk("t4_coll_valid", {31'd0, bus2.rsp_valid_o}, 32'd1);
        chk("t4_coll_old", bus2.rsp_instr_o, 32'h1111_2222);
        hs2();
        issue2(32'h8);
        wait_rsp2(cyc);
        chk("t4_coll_after", bus2.rsp_instr_o, 32'hDEAD_BEEF);
        hs2();

        // Reset during WAIT drops the request
        issue2(32'h4);
        #2 rst_i = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, bus2.rsp_valid_o}, 32'd0);
        chk("t5_async_ready", {31'd0, bus2.req_ready_o}, 32'd1);
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_rsp", {31'd0, bus2.rsp_valid_o}, 32'd0);
            tick();
        end
        chk("t5_ready", {31'd0, bus2.req_ready_o}, 32'd1);
        issue2(32'h0);
        wait_rsp2(cyc);
        chk("t5_refetch", bus2.rsp_instr_o, 32'h2001_0005);
        hs2();

        // Zero wait states, back-to-back with ready held high
        bus0.rsp_ready_i = 1'b1;
        bus0.req_valid_i = 1'b1;
        bus0.req_addr_i  = 32'h0;
        tick();
        chk("t6_a_valid", {31'd0, bus0.rsp_valid_o}, 32'd1);
        chk("t6_a_instr", bus0.rsp_instr_o, 32'h2001_0005);
        chk("t6_a_busy", {31'd0, bus0.req_ready_o}, 32'd0);
        bus0.req_addr_i = 32'h4;
        tick();
        chk("t6_gap_valid", {31'd0, bus0.rsp_valid_o}, 32'd0);
        chk("t6_gap_ready", {31'd0, bus0.req_ready_o}, 32'd1);
        tick();
        bus0.req_valid_i = 1'b0;
        chk("t6_b_valid", {31'd0, bus0.rsp_valid_o}, 32'd1);
        chk("t6_b_instr", bus0.rsp_instr_o, 32'h2002_0003);
        tick();
        chk("t6_b_done", {31'd0, bus0.rsp_valid_o}, 32'd0);
        bus0.rsp_ready_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
